// File: rtl/operand_pair_if.sv
// Handshake bundle between the byte source, the pair loader and the operand unit.
// slave  : loader side (takes bytes, presents pairs, reports level/half).
// master : environment side (drives bytes and out_ready, observes the rest).
interface operand_pair_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [LVL_W-1:0]  level;
    logic              half;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, op_a, op_b, out_valid, level, half
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, op_a, op_b, out_valid, level, half
    );
endinterface

// File: rtl/operand_pair_loader.sv
// Pairs consecutive input bytes into (A, B) operands and buffers them in a
// small show-ahead FIFO feeding the bitwise operand unit.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   clear : synchronous flush of FIFO and any half-formed pair
//   bus   : byte input (in_data/in_valid/in_ready), pair output
//           (op_a/op_b/out_valid/out_ready), status (level, half)
module operand_pair_loader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    operand_pair_if.slave      bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } pair_t;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] a_hold;
    pair_t             mem [DEPTH];
    pair_t             head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              active;
    logic              load_a;
    logic              push;
    logic              pop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign active = !rst && !clear;

    // A is always taken into the hold register; B waits for a free slot.
    // in_ready looks only at the stored count, never at out_ready.
    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        load_a       = 1'b0;
        push         = 1'b0;
        case (state)
            WAIT_A: begin
                bus.in_ready = !clear;
                if (bus.in_valid && active) begin
                    load_a    = 1'b1;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                bus.in_ready = !full && !clear;
                if (bus.in_valid && !full && active) begin
                    push      = 1'b1;
                    state_nxt = WAIT_A;
                end
            end
            default: state_nxt = WAIT_A;
        endcase
    end

    // Pairing state register; rst and clear both drop a pending A.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= WAIT_A;
        end else begin
            state <= state_nxt;
        end
    end

    assign pop = !empty && bus.out_ready && active;

    // Hold register, pointers and explicit occupancy count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            a_hold <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (load_a) begin
                a_hold <= bus.in_data;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Pair storage; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: a_hold, b: bus.in_data};
        end
    end

    // Show-ahead head, forced to zero while empty.
    assign head          = mem[rd_ptr];
    assign bus.op_a      = empty ? '0 : head.a;
    assign bus.op_b      = empty ? '0 : head.b;
    assign bus.out_valid = !empty;
    assign bus.level     = count;
    assign bus.half      = (state == WAIT_B);

endmodule
